// File: rtl/register_file_mp_if.sv
// Register file port bundle: two byte read ports, byte/pair write ports, pointer access and status.
// master drives indices and strobes; slave (the register file) returns read data and status.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   rr_addr;
  logic [DATA_WIDTH-1:0]   rr_data;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    pw_en;
  logic [1:0]              pw_sel;
  logic [2*DATA_WIDTH-1:0] pw_data;
  logic [1:0]              ptr_sel;
  logic [2*DATA_WIDTH-1:0] ptr_data;
  logic                    ptr_upd;
  logic                    ptr_dec;
  logic                    init_busy;
  logic                    collide;

  modport master (
    output rr_addr, rd_addr, wr_en, wr_addr, wr_data,
           pw_en, pw_sel, pw_data, ptr_sel, ptr_upd, ptr_dec,
    input  rr_data, rd_data, ptr_data, init_busy, collide
  );

  modport slave (
    input  rr_addr, rd_addr, wr_en, wr_addr, wr_data,
           pw_en, pw_sel, pw_data, ptr_sel, ptr_upd, ptr_dec,
    output rr_data, rd_data, ptr_data, init_busy, collide
  );
endinterface

// File: rtl/register_file_mp.sv
// AVR register file with X/Y/Z pair access and post-reset clear; writes visible after the capturing edge
// (same cycle with REGFILE_BYPASS_EN). No backpressure: strobes are level-sampled, ignored while init_busy.
module register_file_mp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PTR_BASE   = 26
) (
  input logic               clk,
  input logic               rst_n,
  register_file_mp_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0]   PB       = AW'(PTR_BASE);
  localparam logic [AW-1:0]   IDX_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   IDX_ONE  = AW'(1);
  localparam logic [2*DW-1:0] WORD_ONE = (2*DW)'(1);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic            wr_hit;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_dat;
    logic            pw_hit;
    logic [AW-1:0]   pw_lo;
    logic [2*DW-1:0] pw_dat;
    logic            pt_hit;
    logic [AW-1:0]   pt_lo;
    logic [2*DW-1:0] pt_dat;
  } wsrc_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic          init_busy_q;
  logic          collide_q;
  logic [DW-1:0] mem [DEPTH];

  wsrc_t           src;
  logic            run;
  logic            overlap;
  logic [AW-1:0]   pt_lo;
  logic [AW-1:0]   pt_hi;
  logic [2*DW-1:0] pt_cur;
  logic [DW-1:0]   rr_val;
  logic [DW-1:0]   rd_val;
  logic [DW-1:0]   pl_val;
  logic [DW-1:0]   ph_val;

  function automatic logic [AW-1:0] pair_lo(input logic [1:0] sel);
    return PB + {{(AW-3){1'b0}}, sel, 1'b0};
  endfunction

  function automatic logic [AW-1:0] hi_of(input logic [AW-1:0] lo);
    return {lo[AW-1:1], 1'b1};
  endfunction

  function automatic logic in_pair(input logic [AW-1:0] a, input logic [AW-1:0] lo);
    return a[AW-1:1] == lo[AW-1:1];
  endfunction

  assign run    = (state == RUN);
  // Reserved select 3 wraps to an in-range index; its read is masked and its write suppressed.
  assign pt_lo  = pair_lo(bus.ptr_sel);
  assign pt_hi  = hi_of(pt_lo);
  assign pt_cur = {mem[pt_hi], mem[pt_lo]};

  always_comb begin
    src         = '0;
    src.wr_hit  = run & bus.wr_en;
    src.wr_addr = bus.wr_addr;
    src.wr_dat  = bus.wr_data;
    src.pw_hit  = run & bus.pw_en & (bus.pw_sel != 2'd3);
    src.pw_lo   = pair_lo(bus.pw_sel);
    src.pw_dat  = bus.pw_data;
    src.pt_hit  = run & bus.ptr_upd & (bus.ptr_sel != 2'd3);
    src.pt_lo   = pt_lo;
    src.pt_dat  = bus.ptr_dec ? (pt_cur - WORD_ONE) : (pt_cur + WORD_ONE);
  end

  assign overlap = (src.wr_hit & src.pw_hit & in_pair(src.wr_addr, src.pw_lo))
                 | (src.wr_hit & src.pt_hit & in_pair(src.wr_addr, src.pt_lo))
                 | (src.pw_hit & src.pt_hit & (bus.pw_sel == bus.ptr_sel));

`ifdef REGFILE_BYPASS_EN
  // Forwarded byte follows the same ptr_upd > pw_en > wr_en priority as the array write.
  function automatic logic [DW-1:0] fwd(input wsrc_t s, input logic [AW-1:0] a,
                                        input logic [DW-1:0] base);
    logic [DW-1:0] v;
    v = base;
    if (s.wr_hit && (s.wr_addr == a))
      v = s.wr_dat;
    if (s.pw_hit && in_pair(a, s.pw_lo))
      v = a[0] ? s.pw_dat[2*DW-1:DW] : s.pw_dat[DW-1:0];
    if (s.pt_hit && in_pair(a, s.pt_lo))
      v = a[0] ? s.pt_dat[2*DW-1:DW] : s.pt_dat[DW-1:0];
    return v;
  endfunction

  always_comb begin
    rr_val = fwd(src, bus.rr_addr, mem[bus.rr_addr]);
    rd_val = fwd(src, bus.rd_addr, mem[bus.rd_addr]);
    pl_val = fwd(src, pt_lo, pt_cur[DW-1:0]);
    ph_val = fwd(src, pt_hi, pt_cur[2*DW-1:DW]);
  end
`else
  always_comb begin
    rr_val = mem[bus.rr_addr];
    rd_val = mem[bus.rd_addr];
    pl_val = pt_cur[DW-1:0];
    ph_val = pt_cur[2*DW-1:DW];
  end
`endif

  assign bus.rr_data   = run ? rr_val : '0;
  assign bus.rd_data   = run ? rd_val : '0;
  assign bus.ptr_data  = (run && (bus.ptr_sel != 2'd3)) ? {ph_val, pl_val} : '0;
  assign bus.init_busy = init_busy_q;
  assign bus.collide   = collide_q;

  // Later assignments win, giving ptr_upd > pw_en > wr_en on a shared byte.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[idx] <= '0;
    end else begin
      if (src.wr_hit)
        mem[src.wr_addr] <= src.wr_dat;
      if (src.pw_hit) begin
        mem[src.pw_lo]        <= src.pw_dat[DW-1:0];
        mem[hi_of(src.pw_lo)] <= src.pw_dat[2*DW-1:DW];
      end
      if (src.pt_hit) begin
        mem[src.pt_lo]        <= src.pt_dat[DW-1:0];
        mem[hi_of(src.pt_lo)] <= src.pt_dat[2*DW-1:DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      idx         <= '0;
      init_busy_q <= 1'b1;
      collide_q   <= 1'b0;
    end else begin
      collide_q <= overlap;
      if (state == INIT) begin
        idx <= idx + IDX_ONE;
        if (idx == IDX_LAST) begin
          state       <= RUN;
          init_busy_q <= 1'b0;
        end
      end
    end
  end
endmodule
